// File: rtl/leo_palette_encoder.sv
// leo_palette_encoder
//   Inverse palette lookup: takes a {red,green,blue} pixel and returns the
//   palette index that holds that colour. A single comparator walks the
//   palette one entry per cycle. An exact match ends the walk early, and the
//   lowest matching index wins.
//
//   Optional feature (macro LEO_PALETTE_NEAREST_EN):
//     defined   - on a miss, return the entry with the smallest Manhattan
//                 colour distance. Ties keep the lowest index.
//     undefined - on a miss, return index 0. No distance logic is built.
//
//   Ports
//     Clk, Reset_n                 clock, synchronous active-low reset
//     pal_we/pal_waddr/pal_wdata   palette write port (accepted only in IDLE)
//     pix_valid/pix_ready/pix_rgb  pixel in (ready/valid)
//     idx_valid/idx_ready          result out (ready/valid)
//     idx, idx_exact               encoded index, exact-match flag
module leo_palette_encoder #(
  parameter int NUM_ENTRIES = 16,
  parameter int CH_W        = 4,
  localparam int IW         = $clog2(NUM_ENTRIES),
  localparam int PW         = 3*CH_W
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          pal_we,
  input  logic [IW-1:0] pal_waddr,
  input  logic [PW-1:0] pal_wdata,
  input  logic          pix_valid,
  output logic          pix_ready,
  input  logic [PW-1:0] pix_rgb,
  output logic          idx_valid,
  input  logic          idx_ready,
  output logic [IW-1:0] idx,
  output logic          idx_exact
);

  typedef enum logic [1:0] {IDLE, SEARCH, OUT} state_t;

  state_t                         state, nstate;
  logic [NUM_ENTRIES-1:0][PW-1:0] pal;
  logic [PW-1:0]                  pix_q;
  logic [IW-1:0]                  cnt;
  logic [IW-1:0]                  idx_q;
  logic                           exact_q;
  logic [IW-1:0]                  miss_idx;
  logic                           hit, last, accept;

  // The qualification with Reset_n keeps both handshakes low while reset is
  // held. This blocks an accept into an aborted search and a result pulse
  // from a discarded search.
  assign pix_ready = (state == IDLE) & Reset_n;
  assign idx_valid = (state == OUT) & Reset_n;
  assign idx       = idx_q;
  assign idx_exact = exact_q;

  assign accept = pix_valid & pix_ready;
  assign hit    = (pal[cnt] == pix_q);
  assign last   = (cnt == IW'(NUM_ENTRIES-1));

`ifdef LEO_PALETTE_NEAREST_EN
  localparam int DW = CH_W + 2;   // sum of three CH_W-bit differences

  logic [IW-1:0] best_idx;
  logic [DW-1:0] best_dist;
  logic [DW-1:0] dist;
  logic          closer;

  function automatic logic [CH_W-1:0] absd(input logic [CH_W-1:0] a,
                                           input logic [CH_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  assign dist = DW'(absd(pal[cnt][PW-1:2*CH_W],    pix_q[PW-1:2*CH_W]))
              + DW'(absd(pal[cnt][2*CH_W-1:CH_W],  pix_q[2*CH_W-1:CH_W]))
              + DW'(absd(pal[cnt][CH_W-1:0],       pix_q[CH_W-1:0]));
  // Strict less-than, so an equal distance later in the walk keeps the lower index.
  assign closer   = (dist < best_dist);
  // The entry compared in the last cycle can still be the closest one.
  assign miss_idx = closer ? cnt : best_idx;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      best_idx  <= '0;
      best_dist <= '1;
    end else if (state == IDLE && accept) begin
      best_idx  <= '0;
      best_dist <= '1;
    end else if (state == SEARCH && closer) begin
      best_idx  <= cnt;
      best_dist <= dist;
    end
  end
`else
  assign miss_idx = '0;
`endif

  always_ff @(posedge Clk) begin
    if (!Reset_n) state <= IDLE;
    else          state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (accept)        nstate = SEARCH;
      SEARCH:  if (hit || last)   nstate = OUT;
      OUT:     if (idx_ready)     nstate = IDLE;
      default:                    nstate = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      pal     <= '0;
      pix_q   <= '0;
      cnt     <= '0;
      idx_q   <= '0;
      exact_q <= 1'b0;
    end else begin
      // A write in the accept cycle lands before the first compare, so the
      // new search sees the new entry.
      if (pal_we && state == IDLE) pal[pal_waddr] <= pal_wdata;
      case (state)
        IDLE: if (accept) begin
          pix_q <= pix_rgb;
          cnt   <= '0;
        end
        SEARCH: begin
          if (hit) begin
            idx_q   <= cnt;
            exact_q <= 1'b1;
          end else if (last) begin
            idx_q   <= miss_idx;
            exact_q <= 1'b0;
          end
          // Hold at the top entry. The walk always exits there, so the counter never wraps.
          if (!last) cnt <= cnt + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_leo_palette_encoder.sv
module tb_leo_palette_encoder;

`ifdef LEO_PALETTE_NEAREST_EN
  localparam bit NEAR = 1'b1;
`else
  localparam bit NEAR = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        pal_we = 1'b0;
  logic [3:0]  pal_waddr = '0;
  logic [11:0] pal_wdata = '0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [11:0] pix_rgb = '0;
  logic        idx_valid;
  logic        idx_ready = 1'b1;
  logic [3:0]  idx;
  logic        idx_exact;

  leo_palette_encoder dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .pal_we(pal_we), .pal_waddr(pal_waddr), .pal_wdata(pal_wdata),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_rgb(pix_rgb),
    .idx_valid(idx_valid), .idx_ready(idx_ready), .idx(idx), .idx_exact(idx_exact)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [11:0] pix;
    logic        exact;
    logic [3:0]  idx_def;   // expected index, default build
    logic [3:0]  idx_near;  // expected index, nearest-match build
    int          lat;       // cycles from accept to first idx_valid
  } vec_t;

  typedef struct {
    logic [3:0] idx;
    logic       exact;
    int         lat;
    int         acc;
  } exp_t;

  exp_t        q[$];
  int          ncmp = 0, nfail = 0;
  int          cyc = 0, first_v = 0;
  int          n_send = 0, n_acc = 0;
  logic [3:0]  e_idx = '0;
  logic        e_exact = 1'b0;
  int          e_lat = 0;
  logic [11:0] pal_init [16];
  vec_t        vecs [7];

  task automatic chk(input string nm, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [11:0] d);
    pal_we = 1'b1; pal_waddr = a; pal_wdata = d;
    tick();
    pal_we = 1'b0;
  endtask

  // Offer one pixel and return just after the accepting edge.
  task automatic send(input logic [11:0] p, input logic [3:0] ei,
                      input logic ee, input int el);
    int n = 0;
    e_idx = ei; e_exact = ee; e_lat = el;
    pix_rgb = p; pix_valid = 1'b1;
    n_send++;
    do begin @(negedge Clk); n++; end while (!pix_ready && n < 100);
    if (!pix_ready) chk("accept_timeout", 0, 1);
    @(posedge Clk); #1;
    pix_valid = 1'b0; pal_we = 1'b0;
    pix_rgb = 12'($urandom);   // the in-flight search must ignore this
  endtask

  task automatic wait_done();
    int n = 0;
    while ((q.size() != 0 || idx_valid) && n < 200) begin tick(); n++; end
    chk("drain_queue_empty", q.size(), 0);
  endtask

  initial forever begin @(posedge Clk); cyc++; end

  // Scoreboard: push the expected result on accept, pop and compare on handshake.
  initial begin
    logic vld_d;
    exp_t e;
    vld_d = 1'b0;
    forever begin
      @(negedge Clk);
      if (Reset_n === 1'b1) begin
        if (pix_valid && pix_ready) begin
          e.idx = e_idx; e.exact = e_exact; e.lat = e_lat; e.acc = cyc;
          q.push_back(e);
          n_acc++;
        end
        if (idx_valid && !vld_d) first_v = cyc;
        if (idx_valid && idx_ready) begin
          if (q.size() == 0) chk("unexpected_result", 1, 0);
          else begin
            e = q.pop_front();
            chk("idx", int'(idx), int'(e.idx));
            chk("idx_exact", int'(idx_exact), int'(e.exact));
            chk("latency", first_v - e.acc, e.lat);
          end
        end
      end
      vld_d = idx_valid;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int nv;
    logic [3:0] ex;
    pal_init = '{12'hFFF, 12'h152, 12'h99F, 12'hFC7, 12'h228, 12'h444, 12'h800, 12'h080,
                 12'h008, 12'h444, 12'hA5A, 12'h5A5, 12'h123, 12'hDEF, 12'h777, 12'h0F8};
    //             pix      exact idx_def idx_near lat
    vecs[0] = '{12'hFC7, 1'b1, 4'd3,  4'd3,  5};   // exact at 3
    vecs[1] = '{12'h444, 1'b1, 4'd5,  4'd5,  7};   // duplicate at 5 and 9 -> 5
    vecs[2] = '{12'hFFF, 1'b1, 4'd0,  4'd0,  2};   // first entry
    vecs[3] = '{12'h0F8, 1'b1, 4'd15, 4'd15, 17};  // last entry
    vecs[4] = '{12'hFC8, 1'b0, 4'd0,  4'd3,  17};  // nearest is FC7, distance 1
    vecs[5] = '{12'h000, 1'b0, 4'd0,  4'd12, 17};  // nearest is 123, distance 6
    vecs[6] = '{12'h448, 1'b0, 4'd0,  4'd4,  17};  // tie at distance 4: entries 4, 5, 9

    // Reset
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("pix_ready_in_reset", int'(pix_ready), 0);
    chk("idx_valid_in_reset", int'(idx_valid), 0);
    tick(); Reset_n = 1'b1;
    @(negedge Clk);
    chk("pix_ready_after_reset", int'(pix_ready), 1);
    chk("idx_valid_after_reset", int'(idx_valid), 0);
    chk("idx_after_reset", int'(idx), 0);
    chk("idx_exact_after_reset", int'(idx_exact), 0);
    tick();

    // A cleared palette encodes 000 as an exact hit at entry 0.
    send(12'h000, 4'd0, 1'b1, 2);
    wait_done();

    for (int i = 0; i < 16; i++) wr(4'(i), pal_init[i]);

    foreach (vecs[i]) begin
      send(vecs[i].pix, NEAR ? vecs[i].idx_near : vecs[i].idx_def, vecs[i].exact, vecs[i].lat);
      wait_done();
    end

    // Backpressure: the result holds, and the busy pixel is not accepted.
    idx_ready = 1'b0;
    send(12'hFC7, 4'd3, 1'b1, 5);
    nv = 0;
    while (!idx_valid && nv < 50) begin tick(); nv++; end
    pix_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pix_rgb = 12'($urandom);
      @(negedge Clk);
      chk("bp_pix_ready", int'(pix_ready), 0);
      chk("bp_idx_valid", int'(idx_valid), 1);
      chk("bp_idx", int'(idx), 3);
      chk("bp_idx_exact", int'(idx_exact), 1);
      tick();
    end
    pix_valid = 1'b0; idx_ready = 1'b1;
    tick();
    @(negedge Clk);
    chk("bp_release_idx_valid", int'(idx_valid), 0);
    chk("bp_release_pix_ready", int'(pix_ready), 1);
    tick();

    // A palette write during SEARCH is ignored.
    send(12'hFC8, NEAR ? 4'd3 : 4'd0, 1'b0, 17);
    tick(); tick();
    wr(4'd2, 12'h0F0);
    wait_done();
    send(12'h0F0, NEAR ? 4'd7 : 4'd0, 1'b0, 17);   // entry 2 is still 99F
    wait_done();
    // A write in the accept cycle is seen by the same search.
    pal_we = 1'b1; pal_waddr = 4'd2; pal_wdata = 12'h0F0;
    send(12'h0F0, 4'd2, 1'b1, 4);
    wait_done();

    // Reset during a miss search aborts it and clears the palette.
    send(12'hFC8, NEAR ? 4'd3 : 4'd0, 1'b0, 17);
    repeat (5) tick();
    Reset_n = 1'b0;
    @(negedge Clk);
    chk("abort_pix_ready_in_reset", int'(pix_ready), 0);
    chk("abort_idx_valid_in_reset", int'(idx_valid), 0);
    tick();
    q.delete();
    Reset_n = 1'b1;
    @(negedge Clk);
    chk("abort_pix_ready_after_release", int'(pix_ready), 1);
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (idx_valid) nv++;
    end
    chk("abort_no_idx_valid", nv, 0);
    tick();
    send(12'h000, 4'd0, 1'b1, 2);            // cleared entry 0 matches
    wait_done();
    ex = 4'd0;                               // all entries equal: miss -> 0 either way
    send(12'hFC7, ex, 1'b0, 17);
    wait_done();

    chk("accept_count", n_acc, n_send);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/leo_palette_encoder.md
LEO_PALETTE_ENCODER -- requirements
Module: leo_palette_encoder

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 16, palette depth; index width is 4 bits.
REQ-002 SHALL have parameter CH_W, default 4, bits per colour channel; pixel width is 3*CH_W = 12 bits.
REQ-003 SHALL have ports: Clk  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have ports: Reset_n  in  1  synchronous, active-low reset.
REQ-005 SHALL have ports: pal_we  in  1  palette write strobe; pal_waddr  in  4  entry; pal_wdata  in  12  {red,green,blue}.
REQ-006 SHALL have ports: pix_valid  in  1; pix_ready  out  1; pix_rgb  in  12  {red,green,blue} pixel to encode.
REQ-007 SHALL have ports: idx_valid  out  1; idx_ready  in  1; idx  out  4  encoded palette index; idx_exact  out  1  exact match found.

Function
REQ-008 SHALL implement the inverse of the sprite palette lookup: RGB444 pixel in, 4-bit palette index out.
REQ-009 SHALL hold a 16 x 12-bit register palette, written when pal_we=1 and state is IDLE; pal_we outside IDLE SHALL be ignored.
REQ-010 SHALL use FSM states IDLE, SEARCH, OUT; pix_ready=1 only in IDLE; idx_valid=1 only in OUT.
REQ-011 IDLE: on pix_valid&pix_ready, capture pix_rgb, clear entry counter to 0, clear best registers, go SEARCH.
REQ-012 Simultaneous pal_we and pixel accept in IDLE: write SHALL take effect and be visible to that search.
REQ-013 SEARCH: compare exactly one entry per cycle, entry[cnt], cnt incrementing 0..15.
REQ-014 Exact equality of all 12 bits at entry k SHALL load idx=k, idx_exact=1 and go OUT next cycle (early exit); lowest matching index wins.
REQ-015 Latency: accept at cycle T, entry k compared at T+1+k, idx_valid high from T+2+k; full miss gives idx_valid at T+17.
REQ-016 After cnt=15 with no exact match, go OUT with idx_exact=0 and idx per Configuration.
REQ-017 Counter SHALL not wrap: cnt=15 in SEARCH always exits SEARCH.
REQ-018 OUT: idx, idx_exact held stable until idx_ready=1; on idx_valid&idx_ready go IDLE next cycle.
REQ-019 Throughput: no new pixel accepted before the previous result is consumed; pix_valid while busy SHALL be held off, never dropped.
REQ-020 pix_rgb changes while not IDLE SHALL not affect the in-flight search.

Reset
REQ-021 Reset_n=0 at a rising edge SHALL force IDLE, cnt=0, idx=0, idx_exact=0, idx_valid=0, best distance=max, all palette entries=12'h000.
REQ-022 pix_ready SHALL read 0 while Reset_n=0 and 1 on the first cycle after release.
REQ-023 Reset mid-SEARCH or mid-OUT SHALL abort with no idx_valid pulse; pending result discarded.

Configuration
REQ-024 Macro LEO_PALETTE_NEAREST_EN selects the miss policy.
REQ-025 Defined: SEARCH SHALL track distance |dr|+|dg|+|db| (unsigned 6-bit, max 45) per entry; strictly-smaller updates best, so ties keep the lowest index; miss outputs best index.
REQ-026 Undefined: no distance logic; miss outputs idx=0, idx_exact=0; exact-match behaviour and latency identical.

Verification
REQ-027 Reset, write entries 0..15 with 12'hFFF,152,99F,FC7,228,444,...; encode 12'hFC7 -> idx=3, idx_exact=1, idx_valid 5 cycles after accept.
REQ-028 Palette with 12'h444 at entries 5 and 9, encode 12'h444 -> idx=5, idx_exact=1 (lowest index, early exit).
REQ-029 Encode 12'hFC8 (no match) -> idx_exact=0, idx_valid 17 cycles after accept; idx=3 with LEO_PALETTE_NEAREST_EN (distance 1), idx=0 without.
REQ-030 Hold idx_ready=0 for 10 cycles in OUT with pix_valid=1 and pix_rgb toggling -> idx stable, pix_ready=0, no second accept; release -> IDLE next cycle.
REQ-031 pal_we to entry 2 with 12'h0F0 during SEARCH -> ignored (entry unchanged); same write with accept of 12'h0F0 in IDLE -> idx=2, idx_exact=1.
REQ-032 Assert Reset_n=0 at cycle 6 of a miss search -> no idx_valid, palette reads 12'h000, pix_ready=1 the cycle after release.
